// File: rtl/uart_stim_tx.sv
// UART transmit stimulus: byte FIFO feeding an 8N1 LSB-first serializer.
// Define UART_STIM_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_stim_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       busy,
  output logic                       tx_done,
  output logic                       tx
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_STIM_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tx_q, tx_d;
  logic               tx_done_q, tx_done_d;
  logic               ovf_q, ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic [7:0]         mem [DEPTH];

  logic push, pop, expired;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    div_d     = (div_q == '0) ? div_q : div_q - 1'b1;
    tx_d      = tx_q;
    tx_done_d = 1'b0;
    ovf_d     = ovf_q | (wr_en & full_q);
    pop       = 1'b0;
    push      = wr_en & ~full_q;
    expired   = (div_q == '0);

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty_q) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          tx_d    = 1'b0;
          div_d   = DIV_LOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (expired) begin
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          div_d     = DIV_LOAD;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (expired) begin
          div_d = DIV_LOAD;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_STIM_PARITY_EN
            tx_d    = ^shift_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[bit_idx_q + 3'd1];
          end
        end
      end
`ifdef UART_STIM_PARITY_EN
      S_PARITY: begin
        if (expired) begin
          tx_d    = 1'b1;
          div_d   = DIV_LOAD;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (expired) begin
          tx_done_d = 1'b1;
          div_d     = DIV_LOAD;
          // Chain straight into the next start bit so frames are contiguous.
          if (!empty_q) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      div_q     <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != S_IDLE);
  assign tx_done  = tx_done_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_stim_tx.sv
// Bench for uart_stim_tx: frame-schedule reference model compared every cycle,
// plus directed literal checks. Honors UART_STIM_PARITY_EN like the design.
module tb_uart_stim_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef UART_STIM_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             full, empty, overflow, busy, tx_done, tx;
  logic [CNT_W-1:0] count;

  always #5 clk = ~clk;

  uart_stim_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .busy(busy), .tx_done(tx_done), .tx(tx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: queue of accepted bytes and the position inside the current frame.
  bit         m_valid = 1'b0;
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  logic [7:0] m_cur = 8'h00;
  int         m_el = 0;
  bit         m_ovf = 1'b0;
  bit         m_tx = 1'b1;
  bit         m_done = 1'b0;
  bit         m_empty_pre, m_full_pre;
  int         done_cyc[$];

  function automatic bit frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_STIM_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    if (!rst_n) begin
      m_valid  = 1'b1;
      m_q.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
      m_el     = 0;
    end else begin
      m_empty_pre = (m_q.size() == 0);
      m_full_pre  = (m_q.size() == DEPTH);
      if (m_active) begin
        m_el++;
        if (m_el == FRAME) begin
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end
      if (!m_active && !m_empty_pre) begin
        m_cur    = m_q.pop_front();
        m_active = 1'b1;
        m_el     = 0;
      end
      if (wr_en) begin
        if (m_full_pre) m_ovf = 1'b1;
        else            m_q.push_back(wr_data);
      end
    end
    m_tx = m_active ? frame_bit(m_cur, m_el / CPB) : 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("outputs {tx,busy,done,ovf,full,empty,count}",
            {tx, busy, tx_done, overflow, full, empty, count},
            {m_tx, m_active, m_done, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0),
             CNT_W'(m_q.size())});
      if (tx_done) done_cyc.push_back(cyc);
    end
  end

  // Called at a negedge; holds the write across exactly one rising edge.
  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_active || m_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain within budget", 32'(n < budget), 32'd1);
    @(negedge clk);
  endtask

`ifdef UART_STIM_PARITY_EN
  int exp55[NBITS] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1};
`else
  int exp55[NBITS] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`endif

  initial begin
    int peak;

    // Reset held for three edges, then idle with no writes.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle tx", tx, 1);
    check("idle empty", empty, 1);
    check("idle count", count, 0);
    check("idle busy", busy, 0);

    // Single 0x55 frame against literal bit timing.
    write_byte(8'h55);
    check("0x55 count after write", count, 1);
    for (int k = 1; k <= FRAME + 1; k++) begin
      @(negedge clk);
      if (k == 1) check("0x55 count after pop", count, 0);
      if (k <= FRAME) begin
        check("0x55 tx", tx, exp55[(k-1)/CPB]);
        check("0x55 busy", busy, 1);
        check("0x55 tx_done low", tx_done, 0);
      end else begin
        check("0x55 tx_done pulse", tx_done, 1);
        check("0x55 busy fall", busy, 0);
        check("0x55 tx idle", tx, 1);
      end
    end

    // Burst of three back-to-back frames.
    wait_idle(200);
    done_cyc.delete();
    peak = 0;
    write_byte(8'hA5); if (int'(count) > peak) peak = int'(count);
    write_byte(8'h00); if (int'(count) > peak) peak = int'(count);
    write_byte(8'hFF); if (int'(count) > peak) peak = int'(count);
    wait_idle(4 * FRAME);
    check("burst count peak", peak, 2);
    check("burst tx_done count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("burst spacing 1", done_cyc[1] - done_cyc[0], FRAME);
      check("burst spacing 2", done_cyc[2] - done_cyc[1], FRAME);
    end

    // Overflow: six writes, five accepted.
    check("overflow clear before", overflow, 0);
    for (int i = 0; i < 6; i++) write_byte(8'h10 + 8'(i));
    check("overflow set", overflow, 1);
    check("overflow count full", count, 4);
    check("overflow full flag", full, 1);
    wait_idle(6 * FRAME + 50);
    check("overflow sticky", overflow, 1);

    // Reset during data bit 3 of 0x3C with two bytes queued.
    write_byte(8'h3C);
    write_byte(8'h11);
    write_byte(8'h22);
    repeat (16) @(negedge clk);
    check("0x3C data bit 3", tx, 1);
    check("queued before reset", count, 2);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset tx high", tx, 1);
    check("reset count", count, 0);
    check("reset busy", busy, 0);
    check("reset overflow", overflow, 0);
    done_cyc.delete();
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("no frames after reset", done_cyc.size(), 0);
    check("post-reset tx", tx, 1);

`ifdef UART_STIM_PARITY_EN
    // Parity bit is driven after edges E+37..E+40; sample after E+38.
    write_byte(8'h07);
    repeat (38) @(negedge clk);
    check("parity of 0x07", tx, 1);
    wait_idle(2 * FRAME);
    write_byte(8'h03);
    repeat (38) @(negedge clk);
    check("parity of 0x03", tx, 0);
    wait_idle(2 * FRAME);
`endif

    // Randomized write traffic, including bursts that hit full.
    for (int it = 0; it < 30; it++) begin
      int gap, n;
      gap = $urandom_range(0, 50);
      n   = $urandom_range(1, 6);
      repeat (gap) @(negedge clk);
      for (int j = 0; j < n; j++) write_byte(8'($urandom));
    end
    wait_idle(8 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_stim_tx.md
# uart_stim_tx

Synthesizable UART transmit stimulus stage for the orpsoc simulation bench. It buffers bytes written by bench code or a VPI task into an internal FIFO and serializes them, 8N1 LSB-first, onto a line wired to the SoC's `uart0_srx_pad_i`. It is the RX-side counterpart of the UART decoder that monitors `uart0_stx_pad_o`, and it drives the console input path so that firmware tests can receive characters.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per serial bit (115200 baud at 100 MHz); legal range ≥2.
- `DEPTH`, 16, FIFO entries; power of two, ≥2.
- `clk`  in  1  bench clock; all logic on rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `wr_en`  in  1  write strobe; the byte is accepted on an edge where `wr_en && !full`.
- `wr_data`  in  8  byte to transmit.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `overflow`  out  1  sticky; set when `wr_en` is asserted while `full`.
- `busy`  out  1  high whenever the state is not IDLE.
- `tx_done`  out  1  one-cycle pulse at the end of each frame's stop bit.
- `tx`  out  1  serial line, idle high; connect to `uart0_srx_pad_i`.

## Operation
- Reset (`rst_n` low at an edge): `tx`=1, `busy`=0, `tx_done`=0, `overflow`=0, `count`=0, `empty`=1, `full`=0, FIFO pointers=0, state=IDLE, bit counter=0, divisor=0. Reset asserted mid-frame abandons the frame immediately. `tx` returns high on that edge, and queued bytes are discarded.
- FIFO:
  - Circular buffer of `DEPTH` bytes with read/write pointers of width log2(DEPTH). Pointers wrap from DEPTH-1 to 0.
  - `count` increments on an accepted write and decrements on a pop. A simultaneous write and pop leaves `count` unchanged.
  - A write while `full` is dropped, even if a pop happens on the same edge, and sets `overflow`.
  - `full`, `empty` and `count` are registered. They reflect the state after the edge.
- States:
  - IDLE: `tx`=1. If `!empty`, pop the head into the shift register, set `tx`=0, load the divisor with CLKS_PER_BIT-1, and go to START.
  - START: on divisor expiry, drive `tx`=shift[0], set bit index to 0, and go to DATA.
  - DATA: on each divisor expiry, advance the bit index. After bit 7 expires, go to PARITY when the macro is defined, otherwise drive `tx`=1 and go to STOP.
  - PARITY (macro only): `tx` is even parity, the XOR of the 8 data bits. On expiry, drive `tx`=1 and go to STOP.
  - STOP: on expiry, pulse `tx_done`.
    - If `!empty`, pop the next byte and go directly to START with `tx`=0. There is no idle gap.
    - Otherwise go to IDLE.
- Divisor: a down-counter that reloads CLKS_PER_BIT-1 on every state or bit change. "Expiry" means the counter is 0 at the edge.

## Timing
- Write accepted at edge E into an empty FIFO with IDLE state → `tx` falls at edge E+1. `count` is 1 after E and 0 after E+1.
- Every bit, including start and stop, lasts exactly CLKS_PER_BIT cycles.
- A frame lasts 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- `tx_done` is high for the single cycle following the edge at which the stop bit expires.
- Back-to-back frames: the next start bit begins on the same edge that ends the previous stop bit.
- `busy` rises with the start bit. It falls on the edge that enters IDLE.
- `tx` is a flop output and is glitch-free.

## Configuration
- `UART_STIM_PARITY_EN`:
  - Defined: the PARITY state is compiled in and each frame is 8E1, 11 bits.
  - Undefined: the PARITY state and its logic are absent and frames are 8N1, 10 bits.
  - DUT UART LCR must match.

## Test plan
- Reset/idle (CLKS_PER_BIT=4): hold `rst_n`=0 for 3 edges, then release with no writes → `tx`=1, `empty`=1, `count`=0, `busy`=0 for 100 cycles.
- Single byte 0x55: write at edge E → `tx`=0 during cycles E+1..E+4, then 1,0,1,0,1,0,1,0 in 4-cycle bits, then 1. `tx_done` pulses once at E+41. `busy` falls at E+41.
- Burst of 3 bytes, 0xA5, 0x00, 0xFF, on consecutive cycles → `count` peaks at 2. Three contiguous 40-cycle frames are sent with no idle bit between them. `tx_done` fires 3 times, 40 cycles apart.
- Overflow (DEPTH=4): write 6 bytes back-to-back while the first frame transmits → 5 are accepted (one popped first) and the 6th is dropped. `overflow`=1 and stays 1 until reset. Output order matches accepted order.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0x3C with 2 bytes queued → `tx`=1 after that edge, `count`=0, and no further frames after release.
- Parity (macro defined): send 0x07 → bit 9 = 1. Send 0x03 → bit 9 = 0. Each frame lasts 44 cycles.
